// File: rtl/pulse_width_meter_pkg.sv
// pulse_width_meter_pkg: FSM state encoding and default sizing shared by the meter.
`timescale 1ns/1ps
package pulse_width_meter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, MEASURE = 2'd2, DONE = 2'd3} state_e;
  localparam int NB_DEF = 20;
  localparam int MAX_COUNT_DEF = 1000000;
endpackage

// File: rtl/pulse_width_meter_sync_edge_detect.sv
// pulse_width_meter_sync_edge_detect: 2-FF synchronizer plus history reg; idles high.
`timescale 1ns/1ps
module pulse_width_meter_sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic s_o,
  output logic fall_o,
  output logic rise_o
);
  logic s1_q, s2_q, sp_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      sp_q <= 1'b1;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
      sp_q <= s2_q;
    end
  end
  assign s_o    = s2_q;
  assign fall_o = sp_q & ~s2_q;
  assign rise_o = ~sp_q & s2_q;
endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: arms, captures one active-low pulse width in Tick units, holds it until Ack.
`timescale 1ns/1ps
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int NUMBER_OF_BITS = NB_DEF,
  parameter int MAX_COUNT      = MAX_COUNT_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tick_i,
  input  logic                      arm_i,
  input  logic                      cancel_i,
  input  logic                      signal_i,
  input  logic                      ack_i,
  output logic [NUMBER_OF_BITS-1:0] width_o,
  output logic                      valid_o,
  output logic                      overflow_o,
  output logic                      busy_o
);
  localparam logic [NUMBER_OF_BITS-1:0] MAXV = NUMBER_OF_BITS'(MAX_COUNT);
  state_e                    state_q;
  logic [NUMBER_OF_BITS-1:0] count_q, width_q;
  logic                      ovf_q, s, fall, rise;
  pulse_width_meter_sync_edge_detect u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .sig_i (signal_i),
    .s_o   (s),
    .fall_o(fall),
    .rise_o(rise)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      count_q <= '0;
      width_q <= '0;
      ovf_q   <= 1'b0;
    end else if (cancel_i) begin
      state_q <= IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (arm_i) state_q <= ARMED;
        ARMED: if (fall) begin
          state_q <= MEASURE;
          count_q <= NUMBER_OF_BITS'(tick_i);
        end
        MEASURE: if (rise) begin
          state_q <= DONE;
          width_q <= count_q;
          ovf_q   <= 1'b0;
        end else if (!s && tick_i) begin
          // saturate instead of wrapping: the pulse outlasted the reportable range
          if (count_q == MAXV) begin
            state_q <= DONE;
            width_q <= MAXV;
            ovf_q   <= 1'b1;
          end else count_q <= count_q + 1'b1;
        end
        DONE: if (ack_i) begin
          state_q <= IDLE;
          ovf_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign width_o    = width_q;
  assign valid_o    = state_q == DONE;
  assign overflow_o = ovf_q;
  assign busy_o     = state_q == ARMED || state_q == MEASURE;
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed stimulus, behavioural model compared every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_pulse_width_meter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tick = 1'b1, arm = 1'b0, cancel = 1'b0, signal = 1'b1, ack = 1'b0;
  logic [19:0] w1, w3;
  logic v1, o1, b1, v3, o3, b3;
  int total = 0, bad = 0;
  bit div4 = 0;
  int phase = 0;
  always #5 clk = ~clk;
  pulse_width_meter dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .arm_i(arm), .cancel_i(cancel),
    .signal_i(signal), .ack_i(ack), .width_o(w1), .valid_o(v1), .overflow_o(o1), .busy_o(b1)
  );
  pulse_width_meter #(.NUMBER_OF_BITS(20), .MAX_COUNT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .arm_i(arm), .cancel_i(cancel),
    .signal_i(signal), .ack_i(ack), .width_o(w3), .valid_o(v3), .overflow_o(o3), .busy_o(b3)
  );
  typedef struct {
    int mode;
    int cnt;
    int width;
    bit ovf;
  } mdl_t;
  mdl_t m1, m3;
  bit smp [3];
  function automatic mdl_t step(mdl_t m, bit s, bit sp, int mx);
    mdl_t n = m;
    if (cancel) begin
      n.mode = 0; n.cnt = 0; n.ovf = 0;
    end else if (m.mode == 0) begin
      if (arm) n.mode = 1;
    end else if (m.mode == 1) begin
      if (sp && !s) begin n.mode = 2; n.cnt = tick ? 1 : 0; end
    end else if (m.mode == 2) begin
      if (!sp && s) begin n.mode = 3; n.width = m.cnt; n.ovf = 0; end
      else if (!s && tick) begin
        if (m.cnt == mx) begin n.mode = 3; n.width = mx; n.ovf = 1; end
        else n.cnt = m.cnt + 1;
      end
    end else if (ack) begin
      n.mode = 0; n.ovf = 0;
    end
    return n;
  endfunction
  // line seen by the FSM lags the pin by two samples; the history value by three
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = '{0, 0, 0, 0};
      m3 = '{0, 0, 0, 0};
      smp = '{1, 1, 1};
    end else begin
      m1 = step(m1, smp[1], smp[2], 1000000);
      m3 = step(m3, smp[1], smp[2], 3);
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = signal;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    chk("m1.valid", int'(v1), int'(m1.mode == 3));
    chk("m1.busy", int'(b1), int'(m1.mode == 1 || m1.mode == 2));
    chk("m1.ovf", int'(o1), int'(m1.ovf));
    chk("m1.width", int'(w1), m1.width);
    chk("m3.valid", int'(v3), int'(m3.mode == 3));
    chk("m3.busy", int'(b3), int'(m3.mode == 1 || m3.mode == 2));
    chk("m3.ovf", int'(o3), int'(m3.ovf));
    chk("m3.width", int'(w3), m3.width);
  end
  task automatic tk(input int n);
    repeat (n) begin
      @(negedge clk);
      if (div4) begin
        phase++;
        tick = (phase % 4 == 0);
      end
    end
  endtask
  task automatic do_arm();
    arm = 1'b1;
    tk(1);
    arm = 1'b0;
  endtask
  task automatic pulse(input int n);
    signal = 1'b0;
    tk(n);
    signal = 1'b1;
    tk(6);
  endtask
  task automatic do_ack();
    ack = 1'b1;
    tk(1);
    ack = 1'b0;
  endtask
  initial begin
    tk(2);
    chk("rst.width", int'(w1), 0);
    chk("rst.valid", int'(v1), 0);
    chk("rst.busy", int'(b1), 0);
    chk("rst.ovf", int'(o1), 0);
    rst_n = 1'b1;
    tk(2);
    do_arm();
    signal = 1'b0;
    tk(5);
    chk("mid.busy_before", int'(b1), 1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy_reset", int'(b1), 0);
    chk("mid.valid_reset", int'(v1), 0);
    signal = 1'b1;
    tk(2);
    rst_n = 1'b1;
    tk(8);
    chk("mid.no_result", int'(v1), 0);
    do_arm();
    tk(2);
    pulse(37);
    chk("t2.valid", int'(v1), 1);
    chk("t2.width", int'(w1), 37);
    chk("t2.ovf", int'(o1), 0);
    tk(10);
    chk("t2.hold", int'(v1), 1);
    do_ack();
    chk("t2.ack_clears", int'(v1), 0);
    tk(2);
    div4 = 1;
    phase = 0;
    do_arm();
    tk(2);
    pulse(40);
    chk("t3.width", int'(w1), 10);
    div4 = 0;
    tick = 1'b1;
    do_ack();
    tk(2);
    do_arm();
    tk(2);
    pulse(20);
    chk("t4.width3", int'(w3), 3);
    chk("t4.ovf3", int'(o3), 1);
    chk("t4.width_full", int'(w1), 20);
    tk(5);
    chk("t4.rise_ignored", int'(w3), 3);
    chk("t4.still_valid", int'(v3), 1);
    do_ack();
    tk(2);
    signal = 1'b0;
    tk(4);
    do_arm();
    tk(10);
    chk("t5.waiting", int'(b1), 1);
    chk("t5.no_valid", int'(v1), 0);
    signal = 1'b1;
    tk(5);
    pulse(7);
    chk("t5.width", int'(w1), 7);
    do_arm();
    chk("t5.arm_in_done", int'(v1), 1);
    arm = 1'b1;
    ack = 1'b1;
    tk(1);
    arm = 1'b0;
    ack = 1'b0;
    tk(2);
    chk("t5.arm_ack_idle", int'(b1), 0);
    chk("t5.arm_ack_valid", int'(v1), 0);
    do_arm();
    tk(2);
    cancel = 1'b1;
    tk(1);
    cancel = 1'b0;
    chk("t6.cancel_armed", int'(b1), 0);
    do_arm();
    signal = 1'b0;
    tk(5);
    cancel = 1'b1;
    tk(1);
    cancel = 1'b0;
    chk("t6.cancel_measure", int'(b1), 0);
    chk("t6.width_kept", int'(w1), 7);
    signal = 1'b1;
    tk(5);
    do_arm();
    tk(2);
    pulse(5);
    chk("t6.valid_before", int'(v3), 1);
    cancel = 1'b1;
    ack = 1'b1;
    tk(1);
    cancel = 1'b0;
    ack = 1'b0;
    chk("t6.cancel_done", int'(v1), 0);
    chk("t6.cancel_ovf3", int'(o3), 0);
    tk(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
